// File: rtl/result_writeback_if.sv
// result_writeback_if
//  Tile hand-off between a PE (master) and the result writeback unit (slave).
//  Signals:
//   result_tile_i   DW-bit signed 6x6 result tile, element [0][0] at (result_i_i, result_j_i)
//   result_od_i     output-depth plane of the tile
//   result_i_i      row of element [0][0]
//   result_j_i      column of element [0][0]
//   result_size_i   0: full 6x6 tile, 1: only [0:3][0:3] is meaningful
//   result_acc_i    0: overwrite memory, 1: add into memory
//   result_valid_i  tile present this cycle
//   tile_ready_o    receiver can take a tile; transfer happens on valid & ready
interface result_writeback_if #(
    parameter int DW = 16
);
    logic signed [DW-1:0] result_tile_i [0:5][0:5];
    logic [7:0]           result_od_i;
    logic [8:0]           result_i_i;
    logic [8:0]           result_j_i;
    logic                 result_size_i;
    logic                 result_acc_i;
    logic                 result_valid_i;
    logic                 tile_ready_o;

    modport master (
        output result_tile_i, result_od_i, result_i_i, result_j_i,
        output result_size_i, result_acc_i, result_valid_i,
        input  tile_ready_o
    );

    modport slave (
        input  result_tile_i, result_od_i, result_i_i, result_j_i,
        input  result_size_i, result_acc_i, result_valid_i,
        output tile_ready_o
    );
endinterface

// File: rtl/result_writeback.sv
// result_writeback
//  Receives 6x6 (or 4x4) result tiles from a PE into a small tile FIFO and walks each
//  tile one element per cycle, doing read-modify-write accumulation into a dual-port
//  output SRAM: out[od][i][j] = (acc ? old : 0) + elem, saturated to ACC_W bits.
//  Ports:
//   clk, reset        clock (rising edge) and asynchronous active-high reset
//   rif               tile hand-off (slave side), tile_ready_o back-pressures the PE
//   mem_rd_en_o/addr  SRAM read port, data returns on mem_rdata_i one cycle later
//   mem_wr_en_o/addr/data  SRAM write port
//   busy_o            tiles queued or a write still pending
//   tile_done_o       one-cycle pulse alongside the last write slot of a tile
//   overflow_o        sticky flag: a tile was offered while the FIFO was full
module result_writeback #(
    parameter int DW       = 16,
    parameter int ACC_W    = 32,
    parameter int OUT_H    = 512,
    parameter int OUT_W    = 512,
    parameter int ADDR_W   = 26,
    parameter int FIFO_DEP = 2
) (
    input  logic              clk,
    input  logic              reset,
    result_writeback_if.slave rif,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    input  logic [ACC_W-1:0]  mem_rdata_i,
    output logic              mem_wr_en_o,
    output logic [ADDR_W-1:0] mem_wr_addr_o,
    output logic [ACC_W-1:0]  mem_wr_data_o,
    output logic              busy_o,
    output logic              tile_done_o,
    output logic              overflow_o
);
    localparam int PTR_W = (FIFO_DEP > 1) ? $clog2(FIFO_DEP) : 1;
    localparam int CNT_W = $clog2(FIFO_DEP + 1);
    localparam int PLANE = OUT_H * OUT_W;
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {IDLE, STREAM} state_t;

    logic signed [DW-1:0] fifo_tile [FIFO_DEP][0:5][0:5];
    logic [7:0]           fifo_od   [FIFO_DEP];
    logic [8:0]           fifo_i    [FIFO_DEP];
    logic [8:0]           fifo_j    [FIFO_DEP];
    logic                 fifo_size [FIFO_DEP];
    logic                 fifo_acc  [FIFO_DEP];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_next;
    logic             full, empty, push, pop;

    state_t     state_q, state_d;
    logic [2:0] row_q, row_d, col_q, col_d;
    logic       issue;

    logic signed [DW-1:0] head_elem;
    logic [2:0]           last_idx;
    logic                 elem_last, col_last, in_bounds;
    logic [31:0]          cur_i, cur_j;
    logic [ADDR_W-1:0]    elem_addr;

    logic                 wr_pend_q, wr_acc_q, fwd_hit_q, done_q;
    logic [ADDR_W-1:0]    wr_addr_q;
    logic signed [DW-1:0] wr_elem_q;
    logic [ACC_W-1:0]     fwd_data_q, old_val;
    logic [ACC_W:0]       sum_wide;

    // Ready is taken from the current occupancy only, so a full FIFO never pushes
    // even in a cycle where the head is popped.
    assign full             = (count == CNT_W'(FIFO_DEP));
    assign empty            = (count == '0);
    assign push             = rif.result_valid_i & ~full;
    assign rif.tile_ready_o = ~full;

    // Occupancy bookkeeping for the push/pop combinations.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // FIFO pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEP - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEP - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count_next;
            if (rif.result_valid_i & full)
                overflow_o <= 1'b1;
        end
    end

    // Tile payload storage; contents only matter once counted as occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_tile[wr_ptr] <= rif.result_tile_i;
            fifo_od[wr_ptr]   <= rif.result_od_i;
            fifo_i[wr_ptr]    <= rif.result_i_i;
            fifo_j[wr_ptr]    <= rif.result_j_i;
            fifo_size[wr_ptr] <= rif.result_size_i;
            fifo_acc[wr_ptr]  <= rif.result_acc_i;
        end
    end

    // Current element of the head tile, its address and whether it lands inside
    // the output plane.
    always_comb begin
        head_elem = fifo_tile[rd_ptr][row_q][col_q];
        last_idx  = fifo_size[rd_ptr] ? 3'd3 : 3'd5;
        col_last  = (col_q == last_idx);
        elem_last = col_last && (row_q == last_idx);
        cur_i     = 32'(fifo_i[rd_ptr]) + 32'(row_q);
        cur_j     = 32'(fifo_j[rd_ptr]) + 32'(col_q);
        in_bounds = (cur_i < 32'(OUT_H)) && (cur_j < 32'(OUT_W));
        elem_addr = ADDR_W'(fifo_od[rd_ptr]) * ADDR_W'(PLANE)
                  + ADDR_W'(cur_i) * ADDR_W'(OUT_W) + ADDR_W'(cur_j);
    end

    // Walker state and element counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // The first element is issued in the same cycle the walker leaves IDLE, so a
    // freshly queued tile reads one cycle after it was accepted. At the last
    // element the head is popped and the walker continues straight into the next
    // tile when one is (or is just being) queued.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        issue   = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    issue   = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM:  issue = 1'b1;
            default: state_d = IDLE;
        endcase
        if (issue) begin
            if (elem_last) begin
                row_d   = '0;
                col_d   = '0;
                pop     = 1'b1;
                state_d = ((count == CNT_W'(1)) && !push) ? IDLE : STREAM;
            end else if (col_last) begin
                col_d = '0;
                row_d = row_q + 3'd1;
            end else begin
                col_d = col_q + 3'd1;
            end
        end
    end

    assign mem_rd_en_o   = issue & in_bounds & fifo_acc[rd_ptr];
    assign mem_rd_addr_o = mem_rd_en_o ? elem_addr : '0;

    // Write stage: holds the element whose read data arrives this cycle. When the
    // read hits the address being written in the same cycle, the SRAM would return
    // stale data, so the value being written is captured and used instead.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_pend_q  <= 1'b0;
            wr_addr_q  <= '0;
            wr_elem_q  <= '0;
            wr_acc_q   <= 1'b0;
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            wr_pend_q <= issue & in_bounds;
            done_q    <= issue & elem_last;
            if (issue & in_bounds) begin
                wr_addr_q  <= elem_addr;
                wr_elem_q  <= head_elem;
                wr_acc_q   <= fifo_acc[rd_ptr];
                fwd_hit_q  <= mem_rd_en_o & mem_wr_en_o & (elem_addr == mem_wr_addr_o);
                fwd_data_q <= mem_wr_data_o;
            end
        end
    end

    // One extra bit of headroom: a sign disagreement between the top two bits
    // means the true sum left the ACC_W range and must clamp.
    always_comb begin
        old_val = '0;
        if (wr_acc_q)
            old_val = fwd_hit_q ? fwd_data_q : mem_rdata_i;
        sum_wide = {old_val[ACC_W-1], old_val}
                 + {{(ACC_W + 1 - DW){wr_elem_q[DW-1]}}, wr_elem_q};
        mem_wr_data_o = '0;
        if (wr_pend_q) begin
            if (sum_wide[ACC_W] != sum_wide[ACC_W-1])
                mem_wr_data_o = sum_wide[ACC_W] ? SAT_MIN : SAT_MAX;
            else
                mem_wr_data_o = sum_wide[ACC_W-1:0];
        end
    end

    assign mem_wr_en_o   = wr_pend_q;
    assign mem_wr_addr_o = wr_addr_q;
    assign tile_done_o   = done_q;
    assign busy_o        = ~empty | wr_pend_q;
endmodule
